// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer: state encoding, default sizes
// and the idle levels of the active-low SRAM control strobes.
package fir_pkg;

  localparam int P_TAPS_DEF = 33;
  localparam int P_AW_DEF   = 6;
  localparam int P_DW_DEF   = 16;

  localparam logic RAM_CSN_OFF = 1'b1;
  localparam logic RAM_WRN_OFF = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_SHIFT = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/fir_tap_cnt.sv
// Tap counter for the FIR sequencer: synchronous clear, increment, and a flag
// marking the final tap index.
module fir_tap_cnt #(
  parameter int P_TAPS = 33,
  parameter int P_AW   = 6
) (
  input  logic            iClk_12M,
  input  logic            iRsn,
  input  logic            iClr,
  input  logic            iInc,
  output logic [P_AW-1:0] oCnt,
  output logic            oLast
);

  localparam logic [P_AW-1:0] LP_LAST = P_AW'(P_TAPS - 1);

  logic [P_AW-1:0] r_cnt;

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_cnt <= '0;
    end else if (iClr) begin
      r_cnt <= '0;
    end else if (iInc) begin
      r_cnt <= r_cnt + P_AW'(1);
    end
  end

  assign oCnt  = r_cnt;
  assign oLast = (r_cnt == LP_LAST);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed tap sequencer sharing one coefficient SRAM between host writes
// and filtering. Define FIR_OVERRUN_CNT_EN to add the saturating oOverrunCnt output.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int P_TAPS = P_TAPS_DEF,
  parameter int P_AW   = P_AW_DEF,
  parameter int P_DW   = P_DW_DEF
) (
  input  logic            iClk_12M,
  input  logic            iRsn,
  input  logic            iEnSample,
  input  logic            iHostReq,
  input  logic [P_AW-1:0] iHostAddr,
  input  logic [P_DW-1:0] iHostWrDt,
  input  logic            iClrOverrun,
  output logic            oHostAck,
  output logic            oCsnRam,
  output logic            oWrnRam,
  output logic [P_AW-1:0] oAddrRam,
  output logic [P_DW-1:0] oWrDtRam,
  output logic            oShiftEn,
  output logic            oAccClr,
  output logic            oAccEn,
  output logic [P_AW-1:0] oTapSel,
  output logic            oOutValid,
  output logic            oBusy,
  output logic            oOverrun
`ifdef FIR_OVERRUN_CNT_EN
  ,
  output logic [7:0]      oOverrunCnt
`endif
);

  localparam logic [P_AW:0] LP_TAPS = (P_AW + 1)'(P_TAPS);

  state_e          r_state;
  state_e          w_nextState;
  logic [P_AW-1:0] w_cnt;
  logic            w_last;
  logic            w_inRange;
  logic            w_drop;
  logic            r_accEn;
  logic [P_AW-1:0] r_tapSel;
  logic            r_overrun;

  fir_tap_cnt #(
    .P_TAPS(P_TAPS),
    .P_AW  (P_AW)
  ) u_tapCnt (
    .iClk_12M(iClk_12M),
    .iRsn    (iRsn),
    .iClr    (r_state == S_SHIFT),
    .iInc    (r_state == S_RUN),
    .oCnt    (w_cnt),
    .oLast   (w_last)
  );

  assign w_inRange = ({1'b0, iHostAddr} < LP_TAPS);
  assign w_drop    = iEnSample && (r_state != S_IDLE);

  // A sample strobe has priority over a pending host write in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (iEnSample)     w_nextState = S_SHIFT;
        else if (iHostReq) w_nextState = S_WRITE;
      end
      S_WRITE: w_nextState = S_IDLE;
      S_SHIFT: w_nextState = S_RUN;
      S_RUN:   if (w_last) w_nextState = S_DRAIN;
      S_DRAIN: w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    oCsnRam   = RAM_CSN_OFF;
    oWrnRam   = RAM_WRN_OFF;
    oAddrRam  = '0;
    oWrDtRam  = '0;
    oHostAck  = 1'b0;
    oShiftEn  = 1'b0;
    oAccClr   = 1'b0;
    oOutValid = 1'b0;
    case (r_state)
      S_WRITE: begin
        oCsnRam  = w_inRange ? 1'b0 : RAM_CSN_OFF;
        oWrnRam  = 1'b0;
        oAddrRam = iHostAddr;
        oWrDtRam = iHostWrDt;
        oHostAck = 1'b1;
      end
      S_SHIFT: begin
        oShiftEn = 1'b1;
        oAccClr  = 1'b1;
      end
      S_RUN: begin
        oCsnRam  = 1'b0;
        oAddrRam = w_cnt;
      end
      S_DONE:  oOutValid = 1'b1;
      default: ;
    endcase
  end

  // Accumulate controls trail the SRAM read address by the one-cycle read latency.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_accEn  <= 1'b0;
      r_tapSel <= '0;
    end else begin
      r_accEn  <= (r_state == S_RUN);
      r_tapSel <= (r_state == S_RUN) ? w_cnt : '0;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (iClrOverrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef FIR_OVERRUN_CNT_EN
  logic [7:0] r_overrunCnt;

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_overrunCnt <= 8'd0;
    end else if (w_drop) begin
      if (iClrOverrun)                r_overrunCnt <= 8'd1;
      else if (r_overrunCnt != 8'hFF) r_overrunCnt <= r_overrunCnt + 8'd1;
    end else if (iClrOverrun) begin
      r_overrunCnt <= 8'd0;
    end
  end

  assign oOverrunCnt = r_overrunCnt;
`endif

  assign oAccEn   = r_accEn;
  assign oTapSel  = r_tapSel;
  assign oOverrun = r_overrun;
  assign oBusy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: table of single-cycle host/idle vectors
// plus hand-written multi-cycle sequences for sampling, overrun and reset.
module tb_fir_tap_sequencer;

  localparam int P_TAPS = 33;
  localparam int P_AW   = 6;
  localparam int P_DW   = 16;

  logic            iClk_12M = 1'b0;
  logic            iRsn;
  logic            iEnSample;
  logic            iHostReq;
  logic [P_AW-1:0] iHostAddr;
  logic [P_DW-1:0] iHostWrDt;
  logic            iClrOverrun;
  logic            oHostAck;
  logic            oCsnRam;
  logic            oWrnRam;
  logic [P_AW-1:0] oAddrRam;
  logic [P_DW-1:0] oWrDtRam;
  logic            oShiftEn;
  logic            oAccClr;
  logic            oAccEn;
  logic [P_AW-1:0] oTapSel;
  logic            oOutValid;
  logic            oBusy;
  logic            oOverrun;
`ifdef FIR_OVERRUN_CNT_EN
  logic [7:0]      oOverrunCnt;
`endif

  int testCount = 0;
  int failCount = 0;

  fir_tap_sequencer #(
    .P_TAPS(P_TAPS),
    .P_AW  (P_AW),
    .P_DW  (P_DW)
  ) dut (
    .iClk_12M   (iClk_12M),
    .iRsn       (iRsn),
    .iEnSample  (iEnSample),
    .iHostReq   (iHostReq),
    .iHostAddr  (iHostAddr),
    .iHostWrDt  (iHostWrDt),
    .iClrOverrun(iClrOverrun),
    .oHostAck   (oHostAck),
    .oCsnRam    (oCsnRam),
    .oWrnRam    (oWrnRam),
    .oAddrRam   (oAddrRam),
    .oWrDtRam   (oWrDtRam),
    .oShiftEn   (oShiftEn),
    .oAccClr    (oAccClr),
    .oAccEn     (oAccEn),
    .oTapSel    (oTapSel),
    .oOutValid  (oOutValid),
    .oBusy      (oBusy),
    .oOverrun   (oOverrun)
`ifdef FIR_OVERRUN_CNT_EN
    ,
    .oOverrunCnt(oOverrunCnt)
`endif
  );

  always #5 iClk_12M = ~iClk_12M;

  logic [36:0] wAll;
  assign wAll = {oHostAck, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oShiftEn, oAccClr,
                 oAccEn, oTapSel, oOutValid, oBusy, oOverrun};

  localparam logic [36:0] RST_ALL = {1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 1'b0,
                                     1'b0, 6'd0, 1'b0, 1'b0, 1'b0};

  typedef struct {
    logic        en;
    logic        req;
    logic        clr;
    logic [5:0]  addr;
    logic [15:0] wd;
    logic        expAck;
    logic        expCsn;
    logic        expWrn;
    logic [5:0]  expAddr;
    logic [15:0] expWd;
    logic        expBusy;
    logic        expOvr;
  } vec_t;

  vec_t vecs[8];

  // Move one clock forward and land just after the rising edge.
  task automatic tick();
    @(posedge iClk_12M);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic req, input logic clr,
                               input logic [5:0] addr, input logic [15:0] wd);
    iEnSample   = en;
    iHostReq    = req;
    iClrOverrun = clr;
    iHostAddr   = addr;
    iHostWrDt   = wd;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Expected sample-run outputs for cycle c, counting edge 0 as the strobe edge.
  task automatic checkRunCycle(input int c);
    logic        run;
    logic        acc;
    logic [18:0] e;
    run = (c >= 2) && (c <= P_TAPS + 1);
    acc = (c >= 3) && (c <= P_TAPS + 2);
    e = {(c == 1), (c == 1), acc, (acc ? 6'(c - 3) : 6'd0), (c == P_TAPS + 3),
         ((c >= 1) && (c <= P_TAPS + 3)), !run, 1'b1, (run ? 6'(c - 2) : 6'd0)};
    checkOutput($sformatf("run cycle %0d", c),
                {oShiftEn, oAccClr, oAccEn, oTapSel, oOutValid, oBusy, oCsnRam, oWrnRam, oAddrRam},
                e);
  endtask

  initial begin
    int validCnt;
    int extraShift;
    int busyCnt;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 6'd0,  16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 6'd5,  16'h7FFF, 1'b1, 1'b0, 1'b0, 6'd5,  16'h7FFF, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 6'd0,  16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 6'd40, 16'h1234, 1'b1, 1'b1, 1'b0, 6'd40, 16'h1234, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 6'd0,  16'h0000, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 6'd32, 16'h8001, 1'b1, 1'b0, 1'b0, 6'd32, 16'h8001, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 6'd0,  16'h0000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 6'd0,  16'h0000, 1'b0, 1'b1, 1'b1, 6'd0,  16'h0000, 1'b0, 1'b0};

    iRsn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
    tick();
    tick();
    checkOutput("reset state", wAll, RST_ALL);
    iRsn = 1'b1;
    tick();
    checkOutput("idle after reset", wAll, RST_ALL);

    // Single-cycle host write and idle vectors.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].en, vecs[i].req, vecs[i].clr, vecs[i].addr, vecs[i].wd);
      tick();
      checkOutput($sformatf("vector %0d", i),
                  {oHostAck, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oBusy, oOverrun},
                  {vecs[i].expAck, vecs[i].expCsn, vecs[i].expWrn, vecs[i].expAddr,
                   vecs[i].expWd, vecs[i].expBusy, vecs[i].expOvr});
    end

    // Full sample run timeline.
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
    tick();
    iEnSample = 1'b0;
    for (int c = 1; c <= P_TAPS + 5; c++) begin
      checkRunCycle(c);
      tick();
    end

    // Sample and host request together: sample first, write after returning to IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd7, 16'h00AA);
    tick();
    iEnSample = 1'b0;
    for (int c = 1; c <= P_TAPS + 5; c++) begin
      checkOutput($sformatf("host wait cycle %0d", c), {oHostAck, oOutValid},
                  {(c == P_TAPS + 5), (c == P_TAPS + 3)});
      if (c == P_TAPS + 5)
        checkOutput("deferred write bus", {oCsnRam, oWrnRam, oAddrRam, oWrDtRam},
                    {1'b0, 1'b0, 6'd7, 16'h00AA});
      if (c < P_TAPS + 5) tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
    tick();
    checkOutput("after deferred write", {oHostAck, oBusy}, 2'b00);

    // Strobe during RUN is dropped and flagged.
    validCnt   = 0;
    extraShift = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
    tick();
    for (int c = 1; c <= 40; c++) begin
      if (oOutValid) validCnt++;
      if (c > 1 && oShiftEn) extraShift++;
      if (c == 10) checkOutput("overrun before drop", oOverrun, 1'b0);
      if (c == 11) checkOutput("overrun after drop", oOverrun, 1'b1);
      iEnSample = (c == 10);
      tick();
    end
    checkOutput("single out valid", validCnt, 1);
    checkOutput("no extra shift", extraShift, 0);
    checkOutput("overrun sticky", oOverrun, 1'b1);
    iClrOverrun = 1'b1;
    tick();
    iClrOverrun = 1'b0;
    checkOutput("overrun cleared", oOverrun, 1'b0);

    // Set/clear collision, strobe in DONE dropped, strobe in next IDLE accepted.
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
    tick();
    for (int c = 1; c <= 39; c++) begin
      if (c == 6)  checkOutput("set beats clear", oOverrun, 1'b1);
      if (c == 21) checkOutput("clear mid run", oOverrun, 1'b0);
      if (c == 36) checkOutput("done cycle valid", oOutValid, 1'b1);
      if (c == 37) checkOutput("strobe in done dropped", {oOverrun, oShiftEn, oBusy}, 3'b100);
      if (c == 38) checkOutput("strobe in idle accepted", {oShiftEn, oOverrun}, 2'b11);
      if (c == 39) checkOutput("clear during shift", oOverrun, 1'b0);
      iEnSample   = (c == 5) || (c == 36) || (c == 37);
      iClrOverrun = (c == 5) || (c == 20) || (c == 38);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
    for (int c = 0; c < 40; c++) tick();
    checkOutput("second run finished", oBusy, 1'b0);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
    tick();
    iEnSample = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    checkOutput("in run before reset", {oBusy, oAccEn}, 2'b11);
    #2;
    iRsn = 1'b0;
    #1;
    checkOutput("async reset outputs", wAll, RST_ALL);
    tick();
    iRsn = 1'b1;
    validCnt = 0;
    busyCnt  = 0;
    for (int c = 0; c < 45; c++) begin
      if (oOutValid) validCnt++;
      if (oBusy) busyCnt++;
      tick();
    end
    checkOutput("no valid after reset", validCnt, 0);
    checkOutput("idle after reset abort", busyCnt, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
